// File: rtl/rf_pkg.sv
// rf_pkg: shared types and helpers for register-file write arbitration.
// Widths follow `RF_ADDRESSLEN / `RF_XLEN from RISCV_defs.svh. When that
// header has not been seen, RV32 defaults (5-bit address, 32-bit data) apply.
`ifndef RF_ADDRESSLEN
`define RF_ADDRESSLEN 5
`endif
`ifndef RF_XLEN
`define RF_XLEN 32
`endif

package rf_pkg;

  localparam int ADDR_W = `RF_ADDRESSLEN;
  localparam int XLEN   = `RF_XLEN;

  // One writeback request as presented by a requester.
  typedef struct packed {
    logic                      valid;
    logic [`RF_ADDRESSLEN-1:0] addr;
    logic [`RF_XLEN-1:0]       data;
  } rf_wr_req_t;

  // Which requester owns the write port in the current cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_EX   = 2'd2
  } rf_src_e;

  // x0 is hardwired to zero, so a write to it is accepted but never performed.
  function automatic logic is_x0(input logic [`RF_ADDRESSLEN-1:0] addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/rf_wr_grant.sv
// rf_wr_grant: combinational MEM > EX grant with an EX starvation guard.
// The loss counter counts consecutive cycles in which EX asked and lost; once
// it reaches STARVE_LIMIT the next contended cycle goes to EX. STARVE_LIMIT=0
// disables the guard and leaves pure fixed priority.
module rf_wr_grant
  import rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    mem_valid,
  input  logic    ex_valid,
  output logic    mem_ready,
  output logic    ex_ready,
  output logic    starved,
  output rf_src_e src
);

  // A zero limit still needs a one-bit counter so the declaration is legal.
  localparam int              CNT_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;
  logic             force_ex;

  // Decide the winner from the current requests and the loss history.
  always_comb begin
    force_ex  = (STARVE_LIMIT != 0) && (cnt == CNT_MAX);
    src       = SRC_NONE;
    mem_ready = 1'b0;
    ex_ready  = 1'b0;
    starved   = 1'b0;
    if (!rst) begin
      if (mem_valid && ex_valid) begin
        if (force_ex) begin
          src      = SRC_EX;
          ex_ready = 1'b1;
          starved  = 1'b1;
        end else begin
          src       = SRC_MEM;
          mem_ready = 1'b1;
        end
      end else if (mem_valid) begin
        src       = SRC_MEM;
        mem_ready = 1'b1;
      end else if (ex_valid) begin
        src      = SRC_EX;
        ex_ready = 1'b1;
      end
    end
  end

  // Track consecutive EX losses; any EX grant or idle EX cycle restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!ex_valid || ex_ready) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between MEM and EX.
// The winner of each cycle is registered and drives reg_wr/waddr/wdata on the
// following edge. Writes to x0 are accepted and silently dropped.
// Optional feature macro RF_BYPASS_EN: adds a bypass of the in-flight write
// to two read ports, covering the cycle before register_file has committed it.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [`RF_ADDRESSLEN-1:0] mem_addr,
  input  logic [`RF_XLEN-1:0]       mem_data,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [`RF_ADDRESSLEN-1:0] ex_addr,
  input  logic [`RF_XLEN-1:0]       ex_data,
  output logic                      reg_wr,
  output logic [`RF_ADDRESSLEN-1:0] waddr,
  output logic [`RF_XLEN-1:0]       wdata,
`ifdef RF_BYPASS_EN
  input  logic [`RF_ADDRESSLEN-1:0] byp_raddr1,
  input  logic [`RF_ADDRESSLEN-1:0] byp_raddr2,
  output logic                      byp_hit1,
  output logic                      byp_hit2,
  output logic [`RF_XLEN-1:0]       byp_data1,
  output logic [`RF_XLEN-1:0]       byp_data2,
`endif
  output logic                      starved
);

  rf_wr_req_t mem_req_p0;
  rf_wr_req_t ex_req_p0;
  rf_wr_req_t win_p0;
  rf_src_e    src_p0;
  logic       wr_p0;

  logic                      vld_p1;
  logic [`RF_ADDRESSLEN-1:0] addr_p1;
  logic [`RF_XLEN-1:0]       data_p1;

  assign mem_req_p0 = '{valid: mem_valid, addr: mem_addr, data: mem_data};
  assign ex_req_p0  = '{valid: ex_valid,  addr: ex_addr,  data: ex_data};

  rf_wr_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .ex_valid  (ex_valid),
    .mem_ready (mem_ready),
    .ex_ready  (ex_ready),
    .starved   (starved),
    .src       (src_p0)
  );

  // ---- p0: select the granted request; a write to x0 is consumed but not performed.
  always_comb begin
    win_p0 = '0;
    case (src_p0)
      SRC_MEM: win_p0 = mem_req_p0;
      SRC_EX:  win_p0 = ex_req_p0;
      default: win_p0 = '0;
    endcase
    wr_p0 = win_p0.valid && !is_x0(win_p0.addr);
  end

  // ---- p1: output register toward register_file; address/data hold when no write issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= wr_p0;
      if (wr_p0) begin
        addr_p1 <= win_p0.addr;
        data_p1 <= win_p0.data;
      end
    end
  end

  assign reg_wr = vld_p1;
  assign waddr  = addr_p1;
  assign wdata  = data_p1;

`ifdef RF_BYPASS_EN
  // Forward the in-flight write to readers that would otherwise see the stale value.
  always_comb begin
    byp_hit1  = vld_p1 && (addr_p1 == byp_raddr1) && !is_x0(byp_raddr1);
    byp_hit2  = vld_p1 && (addr_p1 == byp_raddr2) && !is_x0(byp_raddr2);
    byp_data1 = data_p1;
    byp_data2 = data_p1;
  end
`endif

endmodule
